// File: rtl/mac_seq.sv
// mac_seq: tile sequencer and result collector for a single mac PE.
// Joins the activation and weight streams into MAC steps (j outer over
// accumulators, k inner over dot-product length), tracks each step with a
// two-stage tag that lines up with the MAC's registered output, and emits
// the final sum of every accumulator as an indexed result.
module mac_seq #(
    parameter int ACC_W   = 16,
    parameter int K_W     = 8,
    parameter int NUM_ACC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             cfg_k,
    input  logic [$clog2(NUM_ACC)-1:0] cfg_nacc,
    input  logic [1:0]                 cfg_ch,
    input  logic                       act_valid,
    input  logic [ACC_W-1:0]           act_data,
    output logic                       act_ready,
    input  logic                       wt_valid,
    input  logic [ACC_W-1:0]           wt_data,
    output logic                       wt_ready,
    output logic                       mac_clear,
    output logic [2:0]                 mac_valid_ctrl,
    output logic [$clog2(NUM_ACC)-1:0] mac_acc_sel,
    output logic [ACC_W-1:0]           mac_a_0,
    output logic [ACC_W-1:0]           mac_a_1,
    output logic [ACC_W-1:0]           mac_a_2,
    output logic [ACC_W-1:0]           mac_weight,
    input  logic                       mac_valid_out,
    input  logic [ACC_W-1:0]           mac_acc_out,
    output logic                       res_valid,
    output logic [$clog2(NUM_ACC)-1:0] res_idx,
    output logic [ACC_W-1:0]           res_data,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int IDX_W = $clog2(NUM_ACC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_s;

    // Tile configuration, frozen for the whole tile
    logic [K_W-1:0]     k_lat_r;
    logic [IDX_W-1:0]   nacc_lat_r;
    logic [1:0]         ch_lat_r;

    // Step position: j = accumulator, k = position inside the dot product
    logic [IDX_W-1:0]   j_r;
    logic [K_W-1:0]     k_r;

    // Tag pipeline: stage 1 matches the registered step outputs, stage 2
    // matches the MAC's registered valid_out/acc_out
    logic               tag_v1_r;
    logic               tag_last1_r;
    logic [IDX_W-1:0]   tag_idx1_r;
    logic               tag_v2_r;
    logic               tag_last2_r;
    logic [IDX_W-1:0]   tag_idx2_r;

    // High only in the first DRAIN cycle; DRAIN never exits from it
    logic               drain_first_r;

    // Registered outputs
    logic               mac_clear_r;
    logic [2:0]         vc_r;
    logic [IDX_W-1:0]   sel_r;
    logic [ACC_W-1:0]   a0_r;
    logic [ACC_W-1:0]   a1_r;
    logic [ACC_W-1:0]   a2_r;
    logic [ACC_W-1:0]   wt_r;
    logic               res_valid_r;
    logic [IDX_W-1:0]   res_idx_r;
    logic [ACC_W-1:0]   res_data_r;
    logic               busy_r;
    logic               done_r;
    logic               cfg_err_r;

    // Next values of the registered outputs
    logic [2:0]         vc_nx_s;
    logic [IDX_W-1:0]   sel_nx_s;
    logic [ACC_W-1:0]   a0_nx_s;
    logic [ACC_W-1:0]   a1_nx_s;
    logic [ACC_W-1:0]   a2_nx_s;
    logic [ACC_W-1:0]   wt_nx_s;
    logic               cap_s;

    logic               step_s;
    logic               k_last_s;
    logic               j_last_s;
    logic               start_ok_s;
    logic               start_bad_s;
    logic               pipe_empty_s;

    assign step_s       = (state_r == RUN) & act_valid & wt_valid;
    assign k_last_s     = (k_r == (k_lat_r - K_W'(1)));
    assign j_last_s     = (j_r == nacc_lat_r);
    assign start_ok_s   = (state_r == IDLE) & start & (cfg_ch != 2'd3);
    assign start_bad_s  = (state_r == IDLE) & start & (cfg_ch == 2'd3);
    assign pipe_empty_s = ~tag_v1_r & ~tag_v2_r & ~drain_first_r;
    assign cap_s        = mac_valid_out & tag_v2_r & tag_last2_r;

    // The joint handshake is the only unregistered output
    assign act_ready = step_s;
    assign wt_ready  = step_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) next_s = CLEAR;
                else            next_s = IDLE;
            end
            CLEAR: begin
                if (k_lat_r == {K_W{1'b0}}) next_s = DRAIN;
                else                        next_s = RUN;
            end
            RUN: begin
                if (step_s && k_last_s && j_last_s) next_s = DRAIN;
                else                                next_s = RUN;
            end
            DRAIN: begin
                if (pipe_empty_s) next_s = IDLE;
                else              next_s = DRAIN;
            end
            default: next_s = IDLE;
        endcase
    end

    // Step outputs: one-hot channel, routed activation, weight and acc select
    always_comb begin
        vc_nx_s  = 3'b000;
        sel_nx_s = {IDX_W{1'b0}};
        a0_nx_s  = {ACC_W{1'b0}};
        a1_nx_s  = {ACC_W{1'b0}};
        a2_nx_s  = {ACC_W{1'b0}};
        wt_nx_s  = {ACC_W{1'b0}};
        if (step_s) begin
            case (ch_lat_r)
                2'd0: begin
                    vc_nx_s = 3'b001;
                    a0_nx_s = act_data;
                end
                2'd1: begin
                    vc_nx_s = 3'b010;
                    a1_nx_s = act_data;
                end
                2'd2: begin
                    vc_nx_s = 3'b100;
                    a2_nx_s = act_data;
                end
                default: begin
                    vc_nx_s = 3'b000;
                end
            endcase
            wt_nx_s  = wt_data;
            sel_nx_s = j_r;
        end else begin
            vc_nx_s  = 3'b000;
            sel_nx_s = {IDX_W{1'b0}};
        end
    end

    // Configuration latch, step counters, tag pipeline and drain guard
    always_ff @(posedge clk) begin
        if (rst) begin
            k_lat_r       <= {K_W{1'b0}};
            nacc_lat_r    <= {IDX_W{1'b0}};
            ch_lat_r      <= 2'd0;
            j_r           <= {IDX_W{1'b0}};
            k_r           <= {K_W{1'b0}};
            tag_v1_r      <= 1'b0;
            tag_last1_r   <= 1'b0;
            tag_idx1_r    <= {IDX_W{1'b0}};
            tag_v2_r      <= 1'b0;
            tag_last2_r   <= 1'b0;
            tag_idx2_r    <= {IDX_W{1'b0}};
            drain_first_r <= 1'b0;
        end else begin
            if (start_ok_s) begin
                k_lat_r    <= cfg_k;
                nacc_lat_r <= cfg_nacc;
                ch_lat_r   <= cfg_ch;
                j_r        <= {IDX_W{1'b0}};
                k_r        <= {K_W{1'b0}};
            end else if (step_s) begin
                if (k_last_s) begin
                    k_r <= {K_W{1'b0}};
                    j_r <= j_r + IDX_W'(1);
                end else begin
                    k_r <= k_r + K_W'(1);
                end
            end
            tag_v1_r      <= step_s;
            tag_last1_r   <= step_s & k_last_s;
            tag_idx1_r    <= step_s ? j_r : {IDX_W{1'b0}};
            tag_v2_r      <= tag_v1_r;
            tag_last2_r   <= tag_last1_r;
            tag_idx2_r    <= tag_idx1_r;
            drain_first_r <= (state_r != DRAIN) && (next_s == DRAIN);
        end
    end

    // Output registers: MAC drive, result capture and tile status
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_clear_r <= 1'b0;
            vc_r        <= 3'b000;
            sel_r       <= {IDX_W{1'b0}};
            a0_r        <= {ACC_W{1'b0}};
            a1_r        <= {ACC_W{1'b0}};
            a2_r        <= {ACC_W{1'b0}};
            wt_r        <= {ACC_W{1'b0}};
            res_valid_r <= 1'b0;
            res_idx_r   <= {IDX_W{1'b0}};
            res_data_r  <= {ACC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            mac_clear_r <= (next_s == CLEAR);
            vc_r        <= vc_nx_s;
            sel_r       <= sel_nx_s;
            a0_r        <= a0_nx_s;
            a1_r        <= a1_nx_s;
            a2_r        <= a2_nx_s;
            wt_r        <= wt_nx_s;
            res_valid_r <= cap_s;
            res_idx_r   <= cap_s ? tag_idx2_r : {IDX_W{1'b0}};
            res_data_r  <= cap_s ? mac_acc_out : {ACC_W{1'b0}};
            busy_r      <= (next_s != IDLE);
            done_r      <= (state_r == DRAIN) && (next_s == IDLE);
            cfg_err_r   <= start_bad_s;
        end
    end

    assign mac_clear      = mac_clear_r;
    assign mac_valid_ctrl = vc_r;
    assign mac_acc_sel    = sel_r;
    assign mac_a_0        = a0_r;
    assign mac_a_1        = a1_r;
    assign mac_a_2        = a2_r;
    assign mac_weight     = wt_r;
    assign res_valid      = res_valid_r;
    assign res_idx        = res_idx_r;
    assign res_data       = res_data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign cfg_err        = cfg_err_r;

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: a behavioural MAC closes the loop, and expected
// results come from plain dot-product arithmetic over the operand arrays.
module tb_mac_seq;

    localparam int ACC_W = 16;
    localparam int K_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [K_W-1:0]   cfg_k;
    logic [2:0]       cfg_nacc;
    logic [1:0]       cfg_ch;
    logic             act_valid;
    logic [ACC_W-1:0] act_data;
    logic             act_ready;
    logic             wt_valid;
    logic [ACC_W-1:0] wt_data;
    logic             wt_ready;
    logic             mac_clear;
    logic [2:0]       mac_valid_ctrl;
    logic [2:0]       mac_acc_sel;
    logic [ACC_W-1:0] mac_a_0, mac_a_1, mac_a_2, mac_weight;
    logic             mac_valid_out;
    logic [ACC_W-1:0] mac_acc_out;
    logic             res_valid;
    logic [2:0]       res_idx;
    logic [ACC_W-1:0] res_data;
    logic             busy, done, cfg_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_seq #(.ACC_W(ACC_W), .K_W(K_W), .NUM_ACC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_nacc(cfg_nacc),
        .cfg_ch(cfg_ch), .act_valid(act_valid), .act_data(act_data),
        .act_ready(act_ready), .wt_valid(wt_valid), .wt_data(wt_data),
        .wt_ready(wt_ready), .mac_clear(mac_clear), .mac_valid_ctrl(mac_valid_ctrl),
        .mac_acc_sel(mac_acc_sel), .mac_a_0(mac_a_0), .mac_a_1(mac_a_1),
        .mac_a_2(mac_a_2), .mac_weight(mac_weight), .mac_valid_out(mac_valid_out),
        .mac_acc_out(mac_acc_out), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // Behavioural MAC: eight accumulators, one registered stage
    logic [ACC_W-1:0] mac_acc [8];
    logic [ACC_W-1:0] mac_a_sel;
    assign mac_a_sel = mac_valid_ctrl[0] ? mac_a_0 : (mac_valid_ctrl[1] ? mac_a_1 : mac_a_2);

    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 8; m++) mac_acc[m] <= 16'd0;
            mac_valid_out <= 1'b0;
            mac_acc_out   <= 16'd0;
        end else if (mac_clear) begin
            for (int m = 0; m < 8; m++) mac_acc[m] <= 16'd0;
            mac_valid_out <= 1'b0;
        end else if (mac_valid_ctrl != 3'b000) begin
            mac_acc[mac_acc_sel] <= mac_acc[mac_acc_sel] + mac_a_sel * mac_weight;
            mac_acc_out          <= mac_acc[mac_acc_sel] + mac_a_sel * mac_weight;
            mac_valid_out        <= 1'b1;
        end else begin
            mac_valid_out <= 1'b0;
        end
    end

    logic [93:0] outs_s;
    assign outs_s = {mac_clear, mac_valid_ctrl, mac_acc_sel, mac_a_0, mac_a_1, mac_a_2,
                     mac_weight, res_valid, res_idx, res_data, busy, done, cfg_err};

    // Operand streams (element s is the s-th step) and observations
    logic [ACC_W-1:0] act_a [64];
    logic [ACC_W-1:0] wt_a  [64];
    int obs_steps, obs_first_step, obs_last_step, obs_vc_err, obs_sel_err, obs_data_err;
    int obs_ready_err, obs_done_cnt, obs_done_cyc, obs_busy_cnt, obs_clear_cnt;
    int obs_clear_cyc, obs_cfgerr_cnt;
    bit obs_timeout;
    int obs_res_idx[$];
    int obs_res_data[$];
    int obs_res_cyc[$];

    // Reference: accumulator j = dot product of its k operand pairs, mod 2^ACC_W
    function automatic int ref_sum(input int j, input int kk);
        longint s = 0;
        for (int t = 0; t < kk; t++)
            s = (s + longint'(act_a[j*kk+t]) * longint'(wt_a[j*kk+t])) % 65536;
        return int'(s);
    endfunction

    task automatic run_tile(input int nacc, input int kk, input int ch, input int mode,
                            input bit hold_start);
        int n, p, s;
        logic [ACC_W-1:0] e0, e1, e2;
        logic [2:0] exp_vc, exp_sel;
        n = (nacc + 1) * kk; p = 0;
        obs_steps = 0; obs_first_step = -1; obs_last_step = -1; obs_vc_err = 0;
        obs_sel_err = 0; obs_data_err = 0; obs_ready_err = 0; obs_done_cnt = 0;
        obs_done_cyc = -1; obs_busy_cnt = 0; obs_clear_cnt = 0; obs_clear_cyc = -1;
        obs_cfgerr_cnt = 0;
        obs_res_idx.delete(); obs_res_data.delete(); obs_res_cyc.delete();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (mac_clear) begin
                    obs_clear_cnt++;
                    if (obs_clear_cyc < 0) obs_clear_cyc = i;
                end
                if (mac_valid_ctrl != 3'b000) begin
                    s = obs_steps;
                    if (obs_first_step < 0) obs_first_step = i;
                    obs_last_step = i;
                    exp_vc  = 3'b001 << ch;
                    exp_sel = (kk > 0) ? 3'(s / kk) : 3'd0;
                    if (mac_valid_ctrl !== exp_vc) obs_vc_err++;
                    if (mac_acc_sel !== exp_sel) obs_sel_err++;
                    if (s < n) begin
                        e0 = (ch == 0) ? act_a[s] : 16'd0;
                        e1 = (ch == 1) ? act_a[s] : 16'd0;
                        e2 = (ch == 2) ? act_a[s] : 16'd0;
                        if ({mac_a_0, mac_a_1, mac_a_2, mac_weight} !== {e0, e1, e2, wt_a[s]})
                            obs_data_err++;
                    end else begin
                        obs_data_err++;
                    end
                    obs_steps++;
                end else if ({mac_a_0, mac_a_1, mac_a_2, mac_weight} !== 64'd0) begin
                    obs_data_err++;
                end
                if (res_valid) begin
                    obs_res_idx.push_back(int'(res_idx));
                    obs_res_data.push_back(int'(res_data));
                    obs_res_cyc.push_back(i);
                end
                if (done) begin
                    if (obs_done_cnt == 0) obs_done_cyc = i;
                    obs_done_cnt++;
                end
                if (busy) obs_busy_cnt++;
                if (cfg_err) obs_cfgerr_cnt++;
            end
            if (obs_done_cnt > 0 && i >= obs_done_cyc + 3) break;
            if (i == 0) begin
                start = 1'b1; cfg_k = K_W'(kk); cfg_nacc = 3'(nacc); cfg_ch = 2'(ch);
            end else begin
                start = hold_start && busy;
                cfg_k = K_W'($urandom); cfg_nacc = 3'($urandom); cfg_ch = 2'($urandom);
            end
            case (mode)
                0: begin act_valid = 1'b1; wt_valid = 1'b1; end
                1: begin act_valid = 1'b1; wt_valid = (i % 2 == 0); end
                default: begin
                    act_valid = ($urandom_range(0, 3) != 0);
                    wt_valid  = ($urandom_range(0, 3) != 0);
                end
            endcase
            act_data = (p < n) ? act_a[p] : 16'($urandom);
            wt_data  = (p < n) ? wt_a[p]  : 16'($urandom);
            #1;
            if ((act_ready !== wt_ready) || (act_ready && !(act_valid && wt_valid)))
                obs_ready_err++;
            if (act_ready) p++;
        end
        start = 1'b0; act_valid = 1'b0; wt_valid = 1'b0;
        obs_timeout = (obs_done_cnt == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; act_valid = 1'b1; wt_valid = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_s !== 94'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", outs_s);
        end
        checks++;
        if (act_ready !== 1'b0 || wt_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b%b expected 00", act_ready, wt_ready);
        end
        rst = 1'b0; act_valid = 1'b0; wt_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_s !== 94'd0) begin
            failures++; $display("FAIL idle_outputs: got %h expected 0", outs_s);
        end
    endtask

    task automatic test_basic();
        for (int s = 0; s < 6; s++) begin act_a[s] = 16'(s + 1); wt_a[s] = 16'd2; end
        run_tile(1, 3, 1, 0, 1'b1);
        checks++;
        if (obs_timeout || obs_done_cnt != 1) begin
            failures++; $display("FAIL basic_done_count: got %0d expected 1", obs_done_cnt);
        end
        checks++;
        if (obs_steps != 6 || obs_last_step - obs_first_step != 5) begin
            failures++; $display("FAIL basic_steps: got %0d steps over %0d cycles expected 6 over 6",
                                 obs_steps, obs_last_step - obs_first_step + 1);
        end
        checks++;
        if (obs_vc_err + obs_sel_err + obs_data_err != 0) begin
            failures++; $display("FAIL basic_step_fields: vc=%0d sel=%0d data=%0d errors expected 0",
                                 obs_vc_err, obs_sel_err, obs_data_err);
        end
        checks++;
        if (obs_clear_cnt != 1 || obs_clear_cyc < 0 || obs_clear_cyc >= obs_first_step) begin
            failures++; $display("FAIL basic_clear: got %0d pulses at %0d expected 1 before %0d",
                                 obs_clear_cnt, obs_clear_cyc, obs_first_step);
        end
        checks++;
        if (obs_res_idx.size() != 2 || obs_res_idx[0] != 0 || obs_res_data[0] != 12 ||
            obs_res_idx[1] != 1 || obs_res_data[1] != 30) begin
            failures++; $display("FAIL basic_results: got %0d results %p %p expected (0,12) (1,30)",
                                 obs_res_idx.size(), obs_res_idx, obs_res_data);
        end
        checks++;
        if (obs_res_cyc.size() == 0 || obs_done_cyc != obs_res_cyc[obs_res_cyc.size()-1] + 1) begin
            failures++; $display("FAIL basic_done_timing: got cycle %0d expected one after last result",
                                 obs_done_cyc);
        end
        checks++;
        if (obs_cfgerr_cnt != 0) begin
            failures++; $display("FAIL basic_cfg_err: got %0d expected 0", obs_cfgerr_cnt);
        end
    endtask

    task automatic test_wt_gaps();
        for (int s = 0; s < 6; s++) begin act_a[s] = 16'(s + 1); wt_a[s] = 16'd2; end
        run_tile(1, 3, 1, 1, 1'b0);
        checks++;
        if (obs_ready_err != 0) begin
            failures++; $display("FAIL gaps_ready: got %0d bad ready cycles expected 0", obs_ready_err);
        end
        checks++;
        if (obs_steps != 6 || obs_data_err != 0 || obs_sel_err != 0) begin
            failures++; $display("FAIL gaps_steps: got %0d steps, %0d data errs expected 6, 0",
                                 obs_steps, obs_data_err + obs_sel_err);
        end
        checks++;
        if (obs_timeout || obs_res_data.size() != 2 || obs_res_data[0] != 12 || obs_res_data[1] != 30) begin
            failures++; $display("FAIL gaps_results: got %p expected 12 30", obs_res_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 8; s++) begin act_a[s] = 16'(s + 1); wt_a[s] = 16'd3; end
        run_tile(7, 1, 0, 0, 1'b0);
        checks++;
        if (obs_steps != 8 || obs_last_step - obs_first_step != 7 || obs_vc_err + obs_sel_err != 0) begin
            failures++; $display("FAIL b2b_steps: got %0d steps, %0d field errs expected 8 consecutive",
                                 obs_steps, obs_vc_err + obs_sel_err);
        end
        checks++;
        if (obs_res_idx.size() != 8) begin
            failures++; $display("FAIL b2b_res_count: got %0d expected 8", obs_res_idx.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (obs_res_idx[j] != j || obs_res_data[j] != 3 * (j + 1) ||
                    obs_res_cyc[j] != obs_res_cyc[0] + j) begin
                    failures++;
                    $display("FAIL b2b_result%0d: got idx %0d data %0d at +%0d expected idx %0d data %0d at +%0d",
                             j, obs_res_idx[j], obs_res_data[j], obs_res_cyc[j] - obs_res_cyc[0],
                             j, 3 * (j + 1), j);
                end
            end
            checks++;
            if (obs_done_cyc != obs_res_cyc[7] + 1 || obs_done_cnt != 1) begin
                failures++; $display("FAIL b2b_done: got cycle %0d count %0d expected %0d count 1",
                                     obs_done_cyc, obs_done_cnt, obs_res_cyc[7] + 1);
            end
        end
    endtask

    task automatic test_cfg_err();
        int err_seen = 0, bad = 0;
        @(negedge clk);
        start = 1'b1; cfg_ch = 2'd3; cfg_k = 8'd3; cfg_nacc = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cfg_err) err_seen++;
            if (i == 0 && cfg_err !== 1'b1) bad++;
            if (busy || mac_clear) bad++;
        end
        checks++;
        if (err_seen != 1 || bad != 0) begin
            failures++; $display("FAIL cfg_err_pulse: got %0d pulses %0d bad cycles expected 1 and 0",
                                 err_seen, bad);
        end
    endtask

    task automatic test_k_zero();
        run_tile(int'($urandom_range(0, 7)), 0, int'($urandom_range(0, 2)), 0, 1'b1);
        checks++;
        if (obs_clear_cnt != 1 || obs_clear_cyc != 1) begin
            failures++; $display("FAIL kzero_clear: got %0d at %0d expected 1 at 1", obs_clear_cnt, obs_clear_cyc);
        end
        checks++;
        if (obs_steps != 0 || obs_res_idx.size() != 0) begin
            failures++; $display("FAIL kzero_activity: got %0d steps %0d results expected 0 0",
                                 obs_steps, obs_res_idx.size());
        end
        checks++;
        if (obs_done_cnt != 1 || obs_done_cyc != 4 || obs_busy_cnt != 3) begin
            failures++; $display("FAIL kzero_timing: got done %0d at %0d busy %0d expected 1 at 4 busy 3",
                                 obs_done_cnt, obs_done_cyc, obs_busy_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int hs = 0, anomalies = 0;
        for (int s = 0; s < 6; s++) begin act_a[s] = 16'(s + 1); wt_a[s] = 16'd2; end
        for (int i = 0; i < 20 && hs < 2; i++) begin
            @(negedge clk);
            start = (i == 0); cfg_k = 8'd3; cfg_nacc = 3'd1; cfg_ch = 2'd1;
            act_valid = 1'b1; wt_valid = 1'b1;
            act_data = act_a[hs]; wt_data = wt_a[hs];
            #1;
            if (act_ready) hs++;
        end
        checks++;
        if (hs != 2) begin
            failures++; $display("FAIL midrst_setup: got %0d handshakes expected 2", hs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_s !== 94'd0) begin
            failures++; $display("FAIL midrst_outputs: got %h expected 0", outs_s);
        end
        rst = 1'b0; act_valid = 1'b0; wt_valid = 1'b0; start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || res_valid || busy) anomalies++;
        end
        checks++;
        if (anomalies != 0) begin
            failures++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", anomalies);
        end
        run_tile(1, 3, 1, 0, 1'b0);
        checks++;
        if (obs_timeout || obs_res_data.size() != 2 || obs_res_data[0] != 12 || obs_res_data[1] != 30) begin
            failures++; $display("FAIL midrst_fresh_tile: got %p expected 12 30", obs_res_data);
        end
    endtask

    task automatic test_random();
        int nacc, kk, ch, n;
        for (int t = 0; t < 5; t++) begin
            nacc = int'($urandom_range(0, 7));
            kk   = int'($urandom_range(1, 4));
            ch   = int'($urandom_range(0, 2));
            n    = (nacc + 1) * kk;
            for (int s = 0; s < n; s++) begin act_a[s] = 16'($urandom); wt_a[s] = 16'($urandom); end
            run_tile(nacc, kk, ch, 2, 1'b1);
            checks++;
            if (obs_timeout || obs_done_cnt != 1 || obs_steps != n || obs_ready_err != 0) begin
                failures++;
                $display("FAIL rand%0d_flow: got done %0d steps %0d ready errs %0d expected 1 %0d 0",
                         t, obs_done_cnt, obs_steps, obs_ready_err, n);
            end
            checks++;
            if (obs_vc_err + obs_sel_err + obs_data_err != 0) begin
                failures++; $display("FAIL rand%0d_fields: got %0d errors expected 0",
                                     t, obs_vc_err + obs_sel_err + obs_data_err);
            end
            for (int j = 0; j <= nacc; j++) begin
                checks++;
                if (j >= obs_res_idx.size() || obs_res_idx[j] != j || obs_res_data[j] != ref_sum(j, kk)) begin
                    failures++;
                    $display("FAIL rand%0d_result%0d: got %0d results, idx %0d data %0d expected idx %0d data %0d",
                             t, j, obs_res_idx.size(), (j < obs_res_idx.size()) ? obs_res_idx[j] : -1,
                             (j < obs_res_data.size()) ? obs_res_data[j] : -1, j, ref_sum(j, kk));
                end
            end
            checks++;
            if (obs_res_idx.size() != nacc + 1) begin
                failures++; $display("FAIL rand%0d_res_count: got %0d expected %0d",
                                     t, obs_res_idx.size(), nacc + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = 8'd0; cfg_nacc = 3'd0; cfg_ch = 2'd0;
        act_valid = 1'b0; wt_valid = 1'b0; act_data = 16'd0; wt_data = 16'd0;
        test_reset();
        test_basic();
        test_wt_gaps();
        test_back_to_back();
        test_cfg_err();
        test_k_zero();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
